// File: rtl/milestone_monitor_pkg.sv
// Shared types for the milestone monitor: run-state encoding and
// the event record carried through the hit FIFO.
package milestone_pkg;

    localparam int DEF_N_MARKS = 4;
    localparam int DEF_TS_W    = 32;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IDX_W = idx_width(DEF_N_MARKS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } mm_state_e;

    typedef struct packed {
        logic [DEF_IDX_W-1:0] idx;
        logic [DEF_TS_W-1:0]  ts;
    } mm_event_t;

endpackage

// File: rtl/milestone_monitor_if.sv
// Valid/ready event channel from the monitor to its consumer.
// Carries the milestone index and the timestamp of its first hit.
interface milestone_monitor_if
    import milestone_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W,
    parameter int TS_W  = DEF_TS_W
);

    logic             hit_valid_o;
    logic             hit_ready_i;
    logic [IDX_W-1:0] hit_idx_o;
    logic [TS_W-1:0]  hit_time_o;

    modport master (
        output hit_valid_o,
        output hit_idx_o,
        output hit_time_o,
        input  hit_ready_i
    );

    modport slave (
        input  hit_valid_o,
        input  hit_idx_o,
        input  hit_time_o,
        output hit_ready_i
    );

endinterface

// File: rtl/milestone_monitor_fifo.sv
// Synchronous event FIFO; push and pop may share a cycle, even when full.
// DEPTH must be a power of two so the pointers wrap naturally.
module milestone_fifo
    import milestone_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = $bits(mm_event_t)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   used;
    logic          do_push;
    logic          do_pop;

    assign empty   = (used == '0);
    assign full    = (used == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Masked so the output reads zero while nothing is held.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   used <= used + (AW+1)'(1);
                2'b01:   used <= used - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/milestone_monitor.sv
// Milestone monitor: latches first hits of programmable count values.
// Optional stall watchdog compiled in with MILESTONE_MONITOR_WDOG_EN.
module milestone_monitor
    import milestone_pkg::*;
#(
    parameter  int COUNT_W     = 32,
    parameter  int N_MARKS     = 4,
    parameter  int FIFO_DEPTH  = 4,
    parameter  int TS_W        = 32,
    parameter  int WDOG_CYCLES = 600,
    localparam int IDX_W       = idx_width(N_MARKS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [COUNT_W-1:0]              count_i,
    input  logic                            count_valid_i,
    input  logic [N_MARKS-1:0][COUNT_W-1:0] mark_i,
    milestone_monitor_if.master             hit,
    output logic [N_MARKS-1:0]              hits_o,
    output logic                            all_hit_o,
    output logic [1:0]                      state_o,
    output logic                            wdog_o
);

    localparam int EW = IDX_W + TS_W;

    mm_state_e          state;
    logic [TS_W-1:0]    ts;
    logic [TS_W-1:0]    stamp [N_MARKS];
    logic [N_MARKS-1:0] pending;
    logic [N_MARKS-1:0] match;
    logic [N_MARKS-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [TS_W-1:0]    grant_ts;
    logic               cmp_en;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [EW-1:0]      fifo_out;
    logic               done_cond;
    logic               expire;

    assign cmp_en = count_valid_i && (state == IDLE || state == RUN);

    always_comb begin
        match = '0;
        for (int k = 0; k < N_MARKS; k++) begin
            match[k] = cmp_en && !hits_o[k] && (count_i == mark_i[k]);
        end
    end

    // Lowest pending index wins: scan downward so the last hit is the lowest.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_ts  = '0;
        for (int k = N_MARKS - 1; k >= 0; k--) begin
            if (pending[k]) begin
                grant     = '0;
                grant[k]  = 1'b1;
                grant_idx = IDX_W'(k);
                grant_ts  = stamp[k];
            end
        end
    end

    assign pop  = hit.hit_valid_o && hit.hit_ready_i;
    assign push = (|pending) && (!fifo_full || pop);

    milestone_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (EW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({grant_idx, grant_ts}),
        .pop   (pop),
        .dout  (fifo_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign hit.hit_valid_o = !fifo_empty;
    assign hit.hit_idx_o   = fifo_out[EW-1:TS_W];
    assign hit.hit_time_o  = fifo_out[TS_W-1:0];

    assign all_hit_o = &hits_o;
    assign state_o   = state;
    assign done_cond = all_hit_o && fifo_empty && (pending == '0);

`ifdef MILESTONE_MONITOR_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    logic [WW-1:0] wcnt;

    assign expire = (wcnt == WW'(WDOG_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt <= '0;
        end else if ((state == IDLE && count_valid_i) || (|match)) begin
            wcnt <= '0;
        end else if (state == RUN && !expire) begin
            wcnt <= wcnt + WW'(1);
        end
    end
`else
    // Watchdog compiled out; WDOG_CYCLES has no effect.
    assign expire = (WDOG_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ts      <= '0;
            hits_o  <= '0;
            pending <= '0;
            state   <= IDLE;
            wdog_o  <= 1'b0;
            for (int k = 0; k < N_MARKS; k++) begin
                stamp[k] <= '0;
            end
        end else begin
            ts      <= ts + TS_W'(1);
            hits_o  <= hits_o | match;
            pending <= (push ? (pending & ~grant) : pending) | match;
            for (int k = 0; k < N_MARKS; k++) begin
                if (match[k]) begin
                    stamp[k] <= ts;
                end
            end
            unique case (state)
                IDLE: begin
                    if (count_valid_i) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (done_cond) begin
                        state <= DONE;
                    end else if (expire) begin
                        state  <= TIMEOUT;
                        wdog_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_milestone_monitor.sv
// Bench for milestone_monitor: vector table plus event scoreboard.
// Define MILESTONE_MONITOR_WDOG_EN to build the watchdog variant.
module tb_milestone_monitor;
    import milestone_pkg::*;

    localparam int CW = 32;
    localparam int NM = 4;
    localparam int FD = 2;
    localparam int TW = 32;
    localparam int IW = 2;
`ifdef MILESTONE_MONITOR_WDOG_EN
    localparam int WD   = 100;
    localparam bit WDOG = 1'b1;
`else
    localparam int WD   = 600;
    localparam bit WDOG = 1'b0;
`endif
    localparam int NEVER = 1 << 30;

    typedef struct {
        int idx;
        int tm;
        int cyc;
    } ev_t;

    typedef struct {
        logic [NM-1:0][CW-1:0] marks;
        int                    last;
        int                    rdy;
        int                    ncyc;
        bit                    lat;
        int                    vld_at;
        int                    done_at;
        int                    wd_at;
        logic [NM-1:0]         hits;
        logic [1:0]            st;
        bit                    wd;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [CW-1:0]         count_i = '0;
    logic                  count_valid_i = 1'b0;
    logic [NM-1:0][CW-1:0] mark_i = '0;
    logic [NM-1:0]         hits_o;
    logic                  all_hit_o;
    logic [1:0]            state_o;
    logic                  wdog_o;

    milestone_monitor_if #(.IDX_W(IW), .TS_W(TW)) hit_if ();

    milestone_monitor #(
        .COUNT_W     (CW),
        .N_MARKS     (NM),
        .FIFO_DEPTH  (FD),
        .TS_W        (TW),
        .WDOG_CYCLES (WD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .count_i       (count_i),
        .count_valid_i (count_valid_i),
        .mark_i        (mark_i),
        .hit           (hit_if),
        .hits_o        (hits_o),
        .all_hit_o     (all_hit_o),
        .state_o       (state_o),
        .wdog_o        (wdog_o)
    );

    always #5 clk = ~clk;

    int n_run = 0;
    int n_fail = 0;
    int t = 0;
    int last;
    int rdy;
    int stop_at;
    bit lat;
    bit mh [NM];
    logic [NM-1:0][CW-1:0] mk;
    ev_t sbq [$];
    vec_t tv [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", nm, act, exp, t);
        end
    endtask

    task automatic clear_model();
        t = 0;
        sbq.delete();
        for (int k = 0; k < NM; k++) mh[k] = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, hit_if.hit_valid_o, 0);
        chk({tag, "_idx"}, hit_if.hit_idx_o, 0);
        chk({tag, "_time"}, hit_if.hit_time_o, 0);
        chk({tag, "_hits"}, hits_o, 0);
        chk({tag, "_all"}, all_hit_o, 0);
        chk({tag, "_state"}, state_o, IDLE);
        chk({tag, "_wdog"}, wdog_o, 0);
    endtask

    // Drives cycle t, records expected events, scores any pop, advances.
    task automatic step();
        int  rank;
        ev_t e;
        count_i = CW'(t);
        count_valid_i = (t <= last);
        hit_if.hit_ready_i = (t >= rdy);
        rank = 0;
        if (count_valid_i && t < stop_at) begin
            for (int k = 0; k < NM; k++) begin
                if (!mh[k] && mk[k] == CW'(t)) begin
                    mh[k] = 1'b1;
                    sbq.push_back('{k, t, lat ? t + 2 + rank : -1});
                    rank++;
                end
            end
        end
        if (hit_if.hit_valid_o && hit_if.hit_ready_i) begin
            if (sbq.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL extra_event: got idx %0d time %0d, expected none (t=%0d)",
                         hit_if.hit_idx_o, hit_if.hit_time_o, t);
            end else begin
                e = sbq.pop_front();
                chk("ev_idx", hit_if.hit_idx_o, e.idx);
                chk("ev_time", hit_if.hit_time_o, e.tm);
                if (e.cyc >= 0) chk("ev_cycle", t, e.cyc);
            end
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic start(input logic [NM-1:0][CW-1:0] m);
        mk = m;
        mark_i = m;
        reset = 1'b1;
        count_valid_i = 1'b0;
        count_i = '0;
        hit_if.hit_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
        chk_reset_state("reset");
    endtask

    initial begin
        hit_if.hit_ready_i = 1'b0;
        tv[0] = '{marks: {32'd500, 32'd300, 32'd50, 32'd30},
                  last: 499, rdy: 0, ncyc: 520, lat: 1'b1,
                  vld_at: -1, done_at: -1, wd_at: WDOG ? 152 : -1,
                  hits: WDOG ? 4'b0011 : 4'b0111,
                  st: WDOG ? TIMEOUT : RUN, wd: WDOG};
        tv[1] = '{marks: {32'd900, 32'd7, 32'd50, 32'd50},
                  last: 499, rdy: 0, ncyc: 520, lat: 1'b1,
                  vld_at: -1, done_at: -1, wd_at: WDOG ? 152 : -1,
                  hits: 4'b0111,
                  st: WDOG ? TIMEOUT : RUN, wd: WDOG};
        tv[2] = '{marks: {32'd13, 32'd12, 32'd11, 32'd10},
                  last: 20, rdy: 40, ncyc: 60, lat: 1'b0,
                  vld_at: 12, done_at: 45, wd_at: -1,
                  hits: 4'b1111, st: DONE, wd: 1'b0};
        tv[3] = '{marks: {32'd8, 32'd7, 32'd6, 32'd5},
                  last: 8, rdy: 0, ncyc: 20, lat: 1'b1,
                  vld_at: -1, done_at: 12, wd_at: -1,
                  hits: 4'b1111, st: DONE, wd: 1'b0};

        for (int i = 0; i < 4; i++) begin
            start(tv[i].marks);
            last = tv[i].last;
            rdy = tv[i].rdy;
            lat = tv[i].lat;
            stop_at = (tv[i].wd_at >= 0) ? tv[i].wd_at : NEVER;
            while (t < tv[i].ncyc) begin
                if (t == tv[i].vld_at - 1) chk("valid_early", hit_if.hit_valid_o, 0);
                if (t == tv[i].vld_at) chk("valid_first", hit_if.hit_valid_o, 1);
                if (tv[i].vld_at >= 0 && t == tv[i].rdy - 1 && sbq.size() > 0) begin
                    chk("held_valid", hit_if.hit_valid_o, 1);
                    chk("held_idx", hit_if.hit_idx_o, sbq[0].idx);
                    chk("held_time", hit_if.hit_time_o, sbq[0].tm);
                end
                if (t == tv[i].done_at - 1) chk("pre_done_state", state_o, RUN);
                if (t == tv[i].done_at) begin
                    chk("done_state", state_o, DONE);
                    chk("done_all_hit", all_hit_o, 1);
                end
                if (t == tv[i].wd_at - 1) begin
                    chk("pre_wdog", wdog_o, 0);
                    chk("pre_wdog_state", state_o, RUN);
                end
                if (t == tv[i].wd_at) begin
                    chk("wdog", wdog_o, 1);
                    chk("wdog_state", state_o, TIMEOUT);
                end
                step();
            end
            chk("drained", sbq.size(), 0);
            chk("end_hits", hits_o, tv[i].hits);
            chk("end_all_hit", all_hit_o, &tv[i].hits);
            chk("end_state", state_o, tv[i].st);
            chk("end_wdog", wdog_o, tv[i].wd);
        end

        // Reset while an event sits unpopped, then run again.
        start({32'd500, 32'd300, 32'd50, 32'd30});
        last = NEVER;
        rdy = NEVER;
        stop_at = NEVER;
        lat = 1'b0;
        while (t < 40) step();
        chk("pre_reset_valid", hit_if.hit_valid_o, 1);
        chk("pre_reset_idx", hit_if.hit_idx_o, 0);
        chk("pre_reset_time", hit_if.hit_time_o, 30);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_reset_state("mid_reset");
        clear_model();
        rdy = 0;
        lat = 1'b1;
        while (t < 60) step();
        chk("rerun_hits", hits_o, 4'b0011);
        chk("rerun_drained", sbq.size(), 0);
        chk("rerun_state", state_o, RUN);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/milestone_monitor.md
# milestone_monitor

Downstream consumer of the simulation run counter. It watches the counter value each cycle and compares it against N programmable milestone values. It latches the first hit of each milestone together with a cycle timestamp, and presents the hits as ordered events through a valid/ready FIFO. It also tracks run state and, optionally, a stall watchdog, so the bench can report progress and flag milestones that were never reached.

## Interface
- COUNT_W, 32, width of observed counter and milestone values
- N_MARKS, 4, number of milestones (≥1)
- FIFO_DEPTH, 4, event FIFO entries (power of two, ≥2)
- TS_W, 32, timestamp width
- WDOG_CYCLES, 600, cycles with no new hit before timeout (only used with watchdog compiled in)
- clk  in  1  sole clock; all logic on posedge
- reset  in  1  synchronous, active-high; clears all state
- count_i  in  COUNT_W  observed counter value
- count_valid_i  in  1  count_i is meaningful this cycle
- mark_i  in  N_MARKS×COUNT_W  milestone values; quasi-static, must be stable from reset release onward
- hit_valid_o  out  1  event available
- hit_ready_i  in  1  consumer accepts event
- hit_idx_o  out  $clog2(N_MARKS) (min 1)  milestone index of the event
- hit_time_o  out  TS_W  timestamp of the hit
- hits_o  out  N_MARKS  sticky per-milestone hit flags
- all_hit_o  out  1  all hits_o set
- state_o  out  2  run state encoding
- wdog_o  out  1  sticky timeout flag

## Operation
- Timestamp counter ts: 0 in the first cycle after reset release, +1 per cycle, wraps modulo 2^TS_W.
- States: IDLE(0), RUN(1), DONE(2), TIMEOUT(3).
  - IDLE→RUN on the first count_valid_i=1. That cycle is also compared.
  - RUN→DONE when all_hit_o=1 and the FIFO plus pending set are empty.
  - RUN→TIMEOUT on watchdog expiry.
  - DONE and TIMEOUT exit only on reset.
- Match: in IDLE or RUN with count_valid_i=1, every k with count_i==mark_i[k] and hits_o[k]=0 sets hits_o[k] and pending[k], and captures ts_k=ts.
  - Later matches of an already-hit k are ignored.
- Multiple simultaneous matches are all recorded in the same cycle.
- Arbiter: each cycle, the lowest-index pending bit is pushed to the FIFO as {idx, ts_k}, if the FIFO is not full or a pop happens in the same cycle. Its pending bit then clears.
  - Events are never dropped. Back-pressure holds them in pending.
- FIFO: pop occurs when hit_valid_o & hit_ready_i. Output fields are stable while valid and not popped.
  - Push and pop in the same cycle are allowed, including when full.
- TIMEOUT: new matches are disabled. The pending set and FIFO still drain normally.
- Reset mid-operation clears FIFO, pending bits, hits, timestamps and watchdog. State returns to IDLE.

## Timing
- Reset values:
  - hit_valid_o=0, hit_idx_o=0, hit_time_o=0
  - hits_o=0, all_hit_o=0
  - state_o=IDLE, wdog_o=0
- Match in cycle N: hits_o[k] high in N+1; pending push in N+1; hit_valid_o high in N+2 if the FIFO was empty and k is the lowest pending index.
- Each additional simultaneous match adds one cycle per lower-index predecessor.
- all_hit_o is combinational from hits_o (AND-reduce).
- The state register updates one cycle after its condition is true.

## Configuration
- MILESTONE_MONITOR_WDOG_EN defined:
  - Counter resets to 0 on entering RUN and on every new hit.
  - Otherwise it increments while in RUN.
  - When it reaches WDOG_CYCLES: TIMEOUT next cycle, and wdog_o=1 sticky.
- Not defined: no watchdog counter, wdog_o tied 0, TIMEOUT unreachable, WDOG_CYCLES ignored.

## Structure
- Package milestone_pkg holds:
  - the state enum type `mm_state_e` (IDLE/RUN/DONE/TIMEOUT)
  - the event struct typedef (idx, time), parameterised through package-level default widths.
- Sub-module milestone_fifo: synchronous FIFO of event structs with full/empty and simultaneous push/pop. Parameters: depth and data width.
- Top level holds the comparators, sticky flags, pending arbiter, timestamp counter, state machine and watchdog.

## Test plan
- Marks {30,50,300,500}; count_i=ts from reset release with valid=1 through 499; ready=1 → events (0,30), (1,50), (2,300) in order; hits_o=0111; all_hit_o=0; state stays RUN.
- Marks {50,50,7,900}; same stimulus → event (2,7), then (0,50) and (1,50) on consecutive cycles, starting N+2 after the cycle-50 match.
- FIFO_DEPTH=2; marks {10,11,12,13}; ready=0 until ts 40 → hit_valid_o held from ts 12; release ready → exactly 4 events, idx 0..3, times 10..13.
- Marks {5,6,7,8}; run to 8; ready=1 → after the 4th event pops, state_o=DONE one cycle later; all_hit_o=1.
- MILESTONE_MONITOR_WDOG_EN, WDOG_CYCLES=100; marks {30,50,300,500} → wdog_o=1 and state TIMEOUT at ts≈151; the count of 300 is not recorded afterwards.
- Reset asserted at ts 40 with marks {30,…}, with event (0,30) unpopped → next cycle hit_valid_o=0, hits_o=0, state IDLE; a re-run hits again with hit_time_o=30.
